// File: rtl/csirx_pkg.sv
// CSI-2 RX header controller shared types.
// FSM states, header/CRC lengths, DT threshold, output bundle.
package csirx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    CRC,
    WAIT_EOT
  } state_t;

  localparam logic [5:0] DT_LONG_MIN = 6'h10;
  localparam int HDR_LEN = 4;
  localparam int CRC_LEN = 2;

  typedef struct packed {
    logic        hdr_valid;
    logic [7:0]  hdr_di;
    logic [15:0] hdr_wc;
    logic        hdr_short;
    logic        hdr_corrected;
    logic        pay_valid;
    logic [7:0]  pay_data;
    logic        pay_last;
    logic        pkt_done;
    logic        err_ecc;
    logic        err_trunc;
  } out_t;

  function automatic logic is_short(
    input logic [7:0] di
  );
    return di[5:0] < DT_LONG_MIN;
  endfunction

endpackage

// File: rtl/csi_hdr_ctrl_if.sv
// Byte stream in, decoded header / payload / events out.
// slave: the controller side; master: the byte source / sink side.
interface csi_hdr_ctrl_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        eot;
  logic        hdr_valid;
  logic [7:0]  hdr_di;
  logic [15:0] hdr_wc;
  logic        hdr_short;
  logic        hdr_corrected;
  logic        pay_valid;
  logic [7:0]  pay_data;
  logic        pay_last;
  logic        pkt_done;
  logic        err_ecc;
  logic        err_trunc;

  modport slave (
    input  byte_in, byte_valid, eot,
    output hdr_valid, hdr_di, hdr_wc,
    output hdr_short, hdr_corrected,
    output pay_valid, pay_data, pay_last,
    output pkt_done, err_ecc, err_trunc
  );

  modport master (
    output byte_in, byte_valid, eot,
    input  hdr_valid, hdr_di, hdr_wc,
    input  hdr_short, hdr_corrected,
    input  pay_valid, pay_data, pay_last,
    input  pkt_done, err_ecc, err_trunc
  );
endinterface

// File: rtl/ecc_block.sv
// CSI-2 packet header SEC-DED: 24 data bits, ECC in [31:24].
// ph_in: raw header; ph_out: corrected data; one status flag each.
module ecc_block (
  input  logic [31:0] ph_in,
  output logic [23:0] ph_out,
  output logic        no_error,
  output logic        corrected_error,
  output logic        error
);

  // Syndrome of a single flipped data bit, D23 down to D0.
  localparam logic [23:0][5:0] COL = {
    6'h3B, 6'h37, 6'h2F, 6'h1F,
    6'h38, 6'h34, 6'h32, 6'h31,
    6'h2C, 6'h2A, 6'h29, 6'h26,
    6'h25, 6'h23, 6'h1C, 6'h1A,
    6'h19, 6'h16, 6'h15, 6'h13,
    6'h0E, 6'h0D, 6'h0B, 6'h07
  };

  logic [5:0]  calc;
  logic [7:0]  syn;
  logic [23:0] flip;
  logic        par_hit;

  always_comb begin
    calc = '0;
    for (int i = 0; i < 24; i++) begin
      if (ph_in[i]) calc = calc ^ COL[i];
    end
    // P7/P6 are always generated as 0, so a set
    // received bit there is a parity-bit flip.
    syn = {ph_in[31:30], calc ^ ph_in[29:24]};
    flip = '0;
    for (int i = 0; i < 24; i++) begin
      if (syn == {2'b00, COL[i]}) flip[i] = 1'b1;
    end
    par_hit = (syn != 8'h00) &&
              ((syn & (syn - 8'h01)) == 8'h00);
    ph_out = ph_in[23:0] ^ flip;
    no_error = (syn == 8'h00);
    corrected_error = (|flip) || par_hit;
    error = !no_error && !corrected_error;
  end

endmodule

// File: rtl/csi_hdr_ctrl.sv
// CSI-2 RX packet header controller: ECC-checked header decode,
// payload forwarding, CRC skip and saturating packet statistics.
// Ports: clk, rst, bus (byte stream in / header, payload, events
// out), cnt_clear, cnt_pkt / cnt_corr / cnt_uncorr.
module csi_hdr_ctrl
  import csirx_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  csi_hdr_ctrl_if.slave    bus,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] cnt_pkt,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr
);

  state_t      state;
  state_t      nxt;
  state_t      step;
  logic [31:0] ph;
  logic [1:0]  idx;
  logic [15:0] wc_cnt;
  logic [31:0] ecc_in;
  logic [23:0] ph_fix;
  logic        ecc_ok;
  logic        ecc_cor;
  logic        ecc_err;
  logic        hdr_last;
  logic        good;
  logic        fix_short;
  logic [15:0] fix_wc;
  logic        trunc;
  out_t        o_d;
  out_t        o_q;

  assign hdr_last = (state == HEADER) && bus.byte_valid &&
                    (idx == 2'(HDR_LEN - 1));

  // Outside the byte-3 cycle the ECC result is unused.
  assign ecc_in = hdr_last ? {bus.byte_in, ph[23:0]} : ph;

  ecc_block u_ecc (
    .ph_in           (ecc_in),
    .ph_out          (ph_fix),
    .no_error        (ecc_ok),
    .corrected_error (ecc_cor),
    .error           (ecc_err)
  );

  assign good      = ecc_ok || ecc_cor;
  assign fix_short = is_short(ph_fix[7:0]);
  assign fix_wc    = ph_fix[23:8];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // step: where the byte alone takes us; eot then overrides.
  always_comb begin
    step = state;
    unique case (state)
      IDLE:
        if (bus.byte_valid) step = HEADER;
      HEADER:
        if (hdr_last) begin
          if (!good || fix_short) step = WAIT_EOT;
          else if (fix_wc != 16'd0) step = PAYLOAD;
          else step = CRC;
        end
      PAYLOAD:
        if (bus.byte_valid && wc_cnt == 16'd1)
          step = CRC;
      CRC:
        if (bus.byte_valid && idx == 2'(CRC_LEN - 1))
          step = WAIT_EOT;
      WAIT_EOT:
        step = WAIT_EOT;
      default:
        step = IDLE;
    endcase
    nxt = step;
    trunc = 1'b0;
    if (bus.eot && state != IDLE) begin
      nxt = IDLE;
      trunc = (step == HEADER) || (step == PAYLOAD) ||
              (step == CRC);
    end
  end

  always_comb begin
    o_d = '0;
    if (hdr_last && good) begin
      o_d.hdr_valid     = 1'b1;
      o_d.hdr_di        = ph_fix[7:0];
      o_d.hdr_wc        = fix_wc;
      o_d.hdr_short     = fix_short;
      o_d.hdr_corrected = ecc_cor;
      o_d.pkt_done      = fix_short;
    end
    o_d.err_ecc = hdr_last && ecc_err;
    if (state == PAYLOAD && bus.byte_valid) begin
      o_d.pay_valid = 1'b1;
      o_d.pay_data  = bus.byte_in;
      o_d.pay_last  = (wc_cnt == 16'd1);
    end
    if (state == CRC && bus.byte_valid &&
        idx == 2'(CRC_LEN - 1))
      o_d.pkt_done = 1'b1;
    o_d.err_trunc = trunc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph     <= '0;
      idx    <= '0;
      wc_cnt <= '0;
      o_q    <= '0;
    end else begin
      o_q <= o_d;
      case (state)
        IDLE:
          if (bus.byte_valid) begin
            ph  <= {24'h0, bus.byte_in};
            idx <= 2'd1;
          end
        HEADER:
          if (bus.byte_valid) begin
            ph[{idx, 3'b000} +: 8] <= bus.byte_in;
            idx <= idx + 2'd1;
            if (hdr_last) begin
              idx    <= '0;
              wc_cnt <= fix_wc;
            end
          end
        PAYLOAD:
          if (bus.byte_valid) wc_cnt <= wc_cnt - 16'd1;
        CRC:
          if (bus.byte_valid) idx <= idx + 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      cnt_pkt    <= '0;
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else begin
      if (o_d.pkt_done && !(&cnt_pkt))
        cnt_pkt <= cnt_pkt + CNT_W'(1);
      if (hdr_last && ecc_cor && !(&cnt_corr))
        cnt_corr <= cnt_corr + CNT_W'(1);
      if (o_d.err_ecc && !(&cnt_uncorr))
        cnt_uncorr <= cnt_uncorr + CNT_W'(1);
    end
  end

  assign bus.hdr_valid     = o_q.hdr_valid;
  assign bus.hdr_di        = o_q.hdr_di;
  assign bus.hdr_wc        = o_q.hdr_wc;
  assign bus.hdr_short     = o_q.hdr_short;
  assign bus.hdr_corrected = o_q.hdr_corrected;
  assign bus.pay_valid     = o_q.pay_valid;
  assign bus.pay_data      = o_q.pay_data;
  assign bus.pay_last      = o_q.pay_last;
  assign bus.pkt_done      = o_q.pkt_done;
  assign bus.err_ecc       = o_q.err_ecc;
  assign bus.err_trunc     = o_q.err_trunc;

endmodule

// File: tb/tb_csi_hdr_ctrl.sv
// Directed bench for csi_hdr_ctrl (CNT_W=2 to reach saturation).
// Drives and samples on the falling edge; event tallies by monitor.
module tb_csi_hdr_ctrl;
  import csirx_pkg::*;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cnt_clear = 1'b0;
  logic [CW-1:0] cnt_pkt;
  logic [CW-1:0] cnt_corr;
  logic [CW-1:0] cnt_uncorr;

  csi_hdr_ctrl_if bus();

  csi_hdr_ctrl #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cnt_clear  (cnt_clear),
    .cnt_pkt    (cnt_pkt),
    .cnt_corr   (cnt_corr),
    .cnt_uncorr (cnt_uncorr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int hv;
    int pay;
    int last;
    int done;
    int ecc;
    int trunc;
  } tally_t;

  tally_t t = '0;
  tally_t b;
  int n_chk = 0;
  int n_pass = 0;

  always @(negedge clk) begin
    if (bus.hdr_valid) t.hv++;
    if (bus.pay_valid) t.pay++;
    if (bus.pay_last)  t.last++;
    if (bus.pkt_done)  t.done++;
    if (bus.err_ecc)   t.ecc++;
    if (bus.err_trunc) t.trunc++;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] v, input logic e);
    bus.byte_in    = v;
    bus.byte_valid = 1'b1;
    bus.eot        = e;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    bus.eot        = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic end_burst();
    bus.byte_valid = 1'b0;
    bus.eot        = 1'b1;
    @(negedge clk);
    bus.eot        = 1'b0;
    idle(2);
  endtask

  task automatic hdr(input logic [31:0] h);
    for (int i = 0; i < 4; i++) send(h[8*i +: 8], 1'b0);
  endtask

  initial begin
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    bus.eot        = 1'b0;
    idle(3);
    chk("rst_hv", bus.hdr_valid, 0);
    chk("rst_pkt", cnt_pkt, 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    idle(1);

    // good long packet, wc=1
    b = t;
    hdr(32'h09_00_01_10);
    chk("t1_hv", bus.hdr_valid, 1);
    chk("t1_di", bus.hdr_di, 32'h10);
    chk("t1_wc", bus.hdr_wc, 32'h0001);
    chk("t1_short", bus.hdr_short, 0);
    chk("t1_corr", bus.hdr_corrected, 0);
    send(8'hAB, 1'b0);
    chk("t1_pdata", bus.pay_data, 32'hAB);
    chk("t1_plast", bus.pay_last, 1);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    chk("t1_done", bus.pkt_done, 1);
    end_burst();
    chk("t1_npay", t.pay - b.pay, 1);
    chk("t1_ndone", t.done - b.done, 1);
    chk("t1_cnt", cnt_pkt, 1);

    // PH bit 17 flipped: corrected
    b = t;
    hdr(32'h09_02_01_10);
    chk("t2_hv", bus.hdr_valid, 1);
    chk("t2_corr", bus.hdr_corrected, 1);
    chk("t2_wc", bus.hdr_wc, 32'h0001);
    send(8'hAB, 1'b0);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    end_burst();
    chk("t2_ccorr", cnt_corr, 1);
    chk("t2_cpkt", cnt_pkt, 2);
    chk("t2_ndone", t.done - b.done, 1);

    // PH bits 0 and 16 flipped: uncorrectable
    b = t;
    hdr(32'h09_01_01_11);
    chk("t3_eecc", bus.err_ecc, 1);
    send(8'hAB, 1'b0);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    chk("t3_wait", 32'(dut.state), 32'(WAIT_EOT));
    end_burst();
    chk("t3_nhv", t.hv - b.hv, 0);
    chk("t3_necc", t.ecc - b.ecc, 1);
    chk("t3_npay", t.pay - b.pay, 0);
    chk("t3_ndone", t.done - b.done, 0);
    chk("t3_cunc", cnt_uncorr, 1);
    chk("t3_idle", 32'(dut.state), 32'(IDLE));

    // short packet
    b = t;
    hdr(32'h00_00_00_00);
    chk("t4_hv", bus.hdr_valid, 1);
    chk("t4_short", bus.hdr_short, 1);
    chk("t4_done", bus.pkt_done, 1);
    end_burst();
    chk("t4_npay", t.pay - b.pay, 0);
    chk("t4_cpkt", cnt_pkt, 3);

    // wc=3 truncated after 2 payload bytes
    b = t;
    hdr(32'h15_00_03_10);
    chk("t5_wc", bus.hdr_wc, 32'h0003);
    send(8'hAB, 1'b0);
    send(8'hCD, 1'b0);
    end_burst();
    chk("t5_trunc", t.trunc - b.trunc, 1);
    chk("t5_npay", t.pay - b.pay, 2);
    chk("t5_nlast", t.last - b.last, 0);
    chk("t5_ndone", t.done - b.done, 0);
    chk("t5_idle", 32'(dut.state), 32'(IDLE));

    // reset mid-header, then a good packet
    send(8'h10, 1'b0);
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    b = t;
    hdr(32'h09_00_01_10);
    chk("t6_hv", bus.hdr_valid, 1);
    chk("t6_di", bus.hdr_di, 32'h10);
    send(8'hAB, 1'b0);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    end_burst();
    chk("t6_ndone", t.done - b.done, 1);
    chk("t6_ntrunc", t.trunc - b.trunc, 0);
    chk("t6_necc", t.ecc - b.ecc, 0);
    chk("t6_cpkt", cnt_pkt, 1);

    // long wc=0, eot with the last CRC byte
    b = t;
    hdr(32'h18_00_00_12);
    chk("t7_short", bus.hdr_short, 0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b1);
    chk("t7_done", bus.pkt_done, 1);
    chk("t7_idle", 32'(dut.state), 32'(IDLE));
    idle(2);
    chk("t7_ntrunc", t.trunc - b.trunc, 0);
    chk("t7_npay", t.pay - b.pay, 0);
    chk("t7_cpkt", cnt_pkt, 2);

    // clear wins over same-cycle increment
    for (int i = 0; i < 3; i++) send(8'h00, 1'b0);
    cnt_clear = 1'b1;
    send(8'h00, 1'b0);
    cnt_clear = 1'b0;
    chk("t8_done", bus.pkt_done, 1);
    chk("t8_cpkt", cnt_pkt, 0);
    end_burst();

    // saturation
    for (int k = 0; k < 4; k++) begin
      hdr(32'h00_00_00_00);
      end_burst();
    end
    chk("t9_sat", cnt_pkt, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/csi_hdr_ctrl.md
CSI_HDR_CTRL -- requirements
Module: csi_hdr_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each saturating statistics counter.
REQ-002 SHALL have port clk  input  1  single clock; every register updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port byte_in  input  8  byte from the lane merger.
REQ-005 SHALL have port byte_valid  input  1  byte_in valid this cycle; no backpressure.
REQ-006 SHALL have port eot  input  1  end of HS burst, single-cycle pulse.
REQ-007 SHALL have port cnt_clear  input  1  clears all counters.
REQ-008 SHALL have port hdr_valid  output  1  one-cycle pulse; hdr_di, hdr_wc, hdr_short and hdr_corrected are valid.
REQ-009 SHALL have ports hdr_di  output  8, hdr_wc  output  16, hdr_short  output  1, hdr_corrected  output  1  corrected header fields and flags.
REQ-010 SHALL have ports pay_valid  output  1, pay_data  output  8, pay_last  output  1  long-packet payload stream, checksum excluded.
REQ-011 SHALL have ports pkt_done  output  1, err_ecc  output  1, err_trunc  output  1  one-cycle event pulses.
REQ-012 SHALL have ports cnt_pkt, cnt_corr, cnt_uncorr  output  CNT_W each  good-packet, corrected-header and uncorrectable-header counts.

Function
REQ-013 SHALL implement FSM states IDLE, HEADER, PAYLOAD, CRC and WAIT_EOT.
REQ-014 SHALL, on IDLE with byte_valid, store the byte as header byte 0 and enter HEADER.
REQ-015 SHALL store header byte k into PH bits [8k+7:8k], with byte 3 as ECC in [31:24].
REQ-016 SHALL, in the byte 3 cycle, present {byte_in, PH[23:0]} combinationally to ecc_block and register the result on that edge.
REQ-017 SHALL assert hdr_valid in the cycle immediately after byte 3 (latency 1, no bubble).
REQ-018 SHALL take hdr_di from PH_out[7:0] and hdr_wc from PH_out[23:8], both corrected.
REQ-019 SHALL set hdr_short=1 when hdr_di[5:0] < 0x10; long otherwise.
REQ-020 SHALL, on no_error or corrected_error: go to WAIT_EOT if short; go to PAYLOAD if long with WC>0; go to CRC if long with WC=0.
REQ-021 SHALL set hdr_corrected=1, and increment cnt_corr, when the header was corrected.
REQ-022 SHALL, on error, suppress hdr_valid, pulse err_ecc, increment cnt_uncorr and enter WAIT_EOT.
REQ-023 SHALL, in PAYLOAD, forward each valid byte registered with latency 1 on pay_valid and pay_data.
REQ-024 SHALL assert pay_last with the WC-th payload byte, using a 16-bit down-counter.
REQ-025 SHALL, in CRC, consume exactly 2 bytes without forwarding them.
REQ-026 SHALL pulse pkt_done with the 2nd CRC byte, or with hdr_valid for short packets, and increment cnt_pkt; then enter WAIT_EOT.
REQ-027 SHALL, in WAIT_EOT, ignore bytes and return to IDLE on eot.
REQ-028 SHALL, on eot in HEADER, PAYLOAD or CRC, pulse err_trunc, emit no pkt_done, drop the packet and enter IDLE.
REQ-029 SHALL, when byte_valid and eot coincide, process the byte first; if that byte completes the packet, no err_trunc is raised and the FSM enters IDLE.
REQ-030 SHALL ignore eot in IDLE.
REQ-031 SHALL make counters saturate at all-ones.
REQ-032 SHALL give cnt_clear priority over a same-cycle increment.

Reset
REQ-033 SHALL, on rst, force state IDLE, zero the PH register, the byte index and the WC down-counter, and drive every output to 0.
REQ-034 SHALL let rst mid-packet abandon the packet silently, with no err_trunc and no pkt_done.

Structure
REQ-035 SHALL place the FSM state enum, the short/long DT threshold 0x10, header length 4 and CRC length 2 in shared package csirx_pkg.
REQ-036 SHALL instantiate the existing ecc_block as its sole sub-module; ECC logic is not duplicated.

Verification
REQ-037 SHALL drive bytes 10 01 00 09 AB 12 34 then eot -> hdr_valid with di=0x10, wc=0x0001, short=0, corrected=0; one pay byte 0xAB with pay_last; pkt_done; cnt_pkt=1.
REQ-038 SHALL drive the same header with byte 2 = 0x02 (PH bit 17 flipped) -> hdr_corrected=1, hdr_wc=0x0001, cnt_corr=1, packet completes.
REQ-039 SHALL drive header 11 01 01 09 (PH bits 0 and 16 flipped) -> no hdr_valid, err_ecc pulse, cnt_uncorr=1, trailing bytes ignored until eot.
REQ-040 SHALL drive short header 00 00 00 00 -> hdr_short=1 and pkt_done in the same cycle as hdr_valid, no pay_valid.
REQ-041 SHALL drive long header wc=0x0003 with eot after 2 payload bytes -> err_trunc pulse, no pay_last, FSM in IDLE.
REQ-042 SHALL assert rst after header byte 2, then drive a full good packet -> no error pulses, packet decoded normally.
